tnkiii_front_seq: RTL
=====================

// Module: tnkiii_front_seq
// PURPOSE
//  Timing sequencer and CPU/video arbiter for the TNKIII front (sprite) layer.
//  Per scanline it walks the 64 sprite-attribute slots, generating scan address (FH,H3),
//  VCKn/VLK/FCK/LD/LC strobes, and the ROM half-select for the front datapath.
//  It also time-shares the front attribute SRAM with CPU req/ack accesses.
// PARAMETERS
//  NUM_SLOTS    64  sprite slots scanned per line; the slot index drives {FH[4:0],H3}
//  SLOT_PHASES  8   pixel-enable ticks per slot (fixed phase map below)
//  ADDR_W       11  CPU front-RAM address width (VA)
// PORTS
//  clk          in   1       system clock
//  VIDEO_RST    in   1       synchronous, active-high reset
//  pix_ce       in   1       pixel clock enable, one clk wide
//  line_start   in   1       one-clk pulse at start of HBLANK
//  cpu_req      in   1       CPU access request, held until cpu_ack
//  cpu_we       in   1       1=write, 0=read (sampled with cpu_req)
//  cpu_addr     in   ADDR_W  CPU front-RAM address
//  cpu_wdata    in   8       write data
//  cpu_ack      out  1       one-clk completion pulse
//  cpu_rdata    out  8       read data, valid in the cpu_ack cycle
//  ram_rdata    in   8       front-RAM CPU-port data (1-clk sync latency)
//  VA           out  ADDR_W  front-RAM CPU-port address
//  VD_out       out  8       front-RAM write data
//  FRONT_CSn    out  1       CPU-port chip select, active low
//  VWE          out  1       CPU-port write strobe, active low
//  FH           out  5       scan slot index [5:1]
//  H3           out  1       scan slot index [0]
//  VCKn         out  1       scan-port read enable, active low
//  VLK          out  1       attribute latch enable pulse
//  FCK          out  1       second-stage latch pulse
//  FCK_HALF     out  1       ROM half select: 0 for phases 0-3, 1 for phases 4-7
//  LD           out  1       shifter load, active low
//  LC           out  1       colour-bank latch pulse
//  busy         out  1       1 while in SCAN
//  overrun      out  1       sticky: line_start arrived during SCAN
// BEHAVIOUR
//  Reset: state IDLE, slot=0, phase=0. VCKn, FRONT_CSn, VWE and LD go to 1.
//   All other outputs go to 0. overrun is cleared. Any in-flight CPU access is dropped
//   without an ack; a held cpu_req is re-served after reset.
//  FSM: IDLE -> SCAN on line_start. SCAN advances the phase on pix_ce.
//   Phase 7 -> 0 increments slot. At slot NUM_SLOTS-1, phase 7 goes to IDLE (slot wraps to 0).
//  Phase map, strobes one clk wide at the pix_ce tick that enters the phase:
//   p0: VCKn=0, and LC=1 if slot>0 | p1: VLK=1 | p2: FCK=1 | p3, p7: LD=0
//   p4-p6: free window for the CPU.
//   One extra LC pulse accompanies the SCAN->IDLE transition, flushing the last slot.
//  line_start during SCAN: restart at slot 0 phase 0 on the next clk and set overrun.
//   Simultaneous line_start and the final tick: restart wins; overrun is not set.
//  Arbiter: in IDLE, or in SCAN at phases 4-6, a pending cpu_req is granted.
//   Grant cycle: FRONT_CSn=0, VA=cpu_addr, VD_out=cpu_wdata, VWE=~cpu_we.
//   Next clk: cpu_ack=1, and cpu_rdata=ram_rdata on reads.
//   A grant is never issued in the clk where VCKn=0.
//   One access is in flight at a time; cpu_req must be low for >=1 clk after cpu_ack,
//   or it counts as a new request.
//  Worst-case CPU latency is 5 pix_ce periods + 2 clk.
// STRUCTURE
//  Shared package tnkiii_front_pkg: typedef front_seq_state_t {IDLE,SCAN}; phase constants
//   P_SCAN=0, P_VLK=1, P_FCK=2, P_LD0=3, P_FREE_LO=4, P_FREE_HI=6, P_LD1=7.
//  Sub-module tnkiii_front_cpu_arb: grant/ack handshake, fed a cpu_window qualifier.
// TESTING
//  1 Reset then line_start -> 64 slots x 8 phases; FH/H3 step 0..63; exactly 64 VLK, 64 FCK,
//    128 LD pulses and 64 LC pulses (63 in-scan + 1 flush); busy falls after slot 63 p7.
//  2 CPU write 0x5A to 0x7F3 while IDLE -> FRONT_CSn low 1 clk with VA=0x7F3, VWE=0;
//    cpu_ack on the next clk.
//  3 CPU read issued at phase 0 of slot 10 -> no grant until p4; cpu_rdata equals
//    model RAM contents; VCKn and FRONT_CSn never low in the same clk.
//  4 line_start at slot 30 p5 -> next clk is slot 0 p0 and overrun=1;
//    line_start on the final tick -> overrun stays 0.
//  5 VIDEO_RST asserted mid-grant -> no cpu_ack; all outputs at reset values next clk;
//    held cpu_req is acked after reset.
//  6 Random pix_ce gaps with back-to-back CPU traffic -> phase map unchanged;
//    every request acked within the latency bound.

Source files
------------

// File: rtl/tnkiii_front_pkg.sv
// Shared types and phase constants for the TNKIII front (sprite) layer sequencer.
package tnkiii_front_pkg;

  localparam int NUM_SLOTS    = 64;
  localparam int SLOT_PHASES  = 8;
  localparam int SLOT_W       = $clog2(NUM_SLOTS);
  localparam int PHASE_W      = $clog2(SLOT_PHASES);
  localparam int FRONT_ADDR_W = 11;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } front_seq_state_t;

  localparam logic [PHASE_W-1:0] P_SCAN    = PHASE_W'(0);
  localparam logic [PHASE_W-1:0] P_VLK     = PHASE_W'(1);
  localparam logic [PHASE_W-1:0] P_FCK     = PHASE_W'(2);
  localparam logic [PHASE_W-1:0] P_LD0     = PHASE_W'(3);
  localparam logic [PHASE_W-1:0] P_FREE_LO = PHASE_W'(4);
  localparam logic [PHASE_W-1:0] P_FREE_HI = PHASE_W'(6);
  localparam logic [PHASE_W-1:0] P_LD1     = PHASE_W'(7);

  localparam logic [SLOT_W-1:0]  LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);

  function automatic logic is_free_phase(input logic [PHASE_W-1:0] ph);
    return (ph >= P_FREE_LO) && (ph <= P_FREE_HI);
  endfunction

endpackage

// File: rtl/tnkiii_front_cpu_arb.sv
// CPU access handshake for the front attribute SRAM: one grant clk, then a one-clk ack.
module tnkiii_front_cpu_arb
  import tnkiii_front_pkg::*;
#(
  parameter int ADDR_W = FRONT_ADDR_W
) (
  input  logic              clk,
  input  logic              i_rst,
  input  logic              i_window,
  input  logic              i_req,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [7:0]        i_wdata,
  input  logic [7:0]        i_ram_rdata,
  output logic              o_ack,
  output logic [7:0]        o_rdata,
  output logic [ADDR_W-1:0] o_va,
  output logic [7:0]        o_vd,
  output logic              o_csn,
  output logic              o_vwe
);

  logic              r_gnt;
  logic              r_ack;
  logic              r_we;
  logic [ADDR_W-1:0] r_va;
  logic [7:0]        r_vd;
  logic              w_grant;

  // i_window describes the cycle the grant would occupy; the ack cycle is
  // excluded so a still-high cpu_req there is not mistaken for a new request.
  assign w_grant = i_req && i_window && !r_gnt && !r_ack;

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_gnt <= 1'b0;
      r_ack <= 1'b0;
      r_we  <= 1'b0;
      r_va  <= '0;
      r_vd  <= '0;
    end else begin
      r_gnt <= w_grant;
      r_ack <= r_gnt;
      if (w_grant) begin
        r_va <= i_addr;
        r_vd <= i_wdata;
        r_we <= i_we;
      end
    end
  end

  assign o_ack   = r_ack;
  assign o_rdata = (r_ack && !r_we) ? i_ram_rdata : '0;
  assign o_va    = r_gnt ? r_va : '0;
  assign o_vd    = r_gnt ? r_vd : '0;
  assign o_csn   = ~r_gnt;
  assign o_vwe   = ~(r_gnt && r_we);

endmodule

// File: rtl/tnkiii_front_seq.sv
// TNKIII front-layer sequencer: walks 64 sprite slots x 8 phases per scanline and
// time-shares the front attribute SRAM CPU port via tnkiii_front_cpu_arb.
module tnkiii_front_seq
  import tnkiii_front_pkg::*;
#(
  parameter int ADDR_W = FRONT_ADDR_W
) (
  input  logic              clk,
  input  logic              VIDEO_RST,
  input  logic              pix_ce,
  input  logic              line_start,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic              cpu_ack,
  output logic [7:0]        cpu_rdata,
  input  logic [7:0]        ram_rdata,
  output logic [ADDR_W-1:0] VA,
  output logic [7:0]        VD_out,
  output logic              FRONT_CSn,
  output logic              VWE,
  output logic [4:0]        FH,
  output logic              H3,
  output logic              VCKn,
  output logic              VLK,
  output logic              FCK,
  output logic              FCK_HALF,
  output logic              LD,
  output logic              LC,
  output logic              busy,
  output logic              overrun
);

  front_seq_state_t   r_state, w_state_nx;
  logic [SLOT_W-1:0]  r_slot, w_slot_nx;
  logic [PHASE_W-1:0] r_phase, w_phase_nx;
  logic               w_enter;
  logic               w_flush;
  logic               w_overrun_set;
  logic               w_last_tick;
  logic               w_window_nx;
  logic               r_vckn, r_vlk, r_fck, r_ldn, r_lc, r_overrun;

  always_ff @(posedge clk) begin
    if (VIDEO_RST) begin
      r_state <= IDLE;
      r_slot  <= '0;
      r_phase <= '0;
    end else begin
      r_state <= w_state_nx;
      r_slot  <= w_slot_nx;
      r_phase <= w_phase_nx;
    end
  end

  assign w_last_tick = (r_state == SCAN) && pix_ce &&
                       (r_slot == LAST_SLOT) && (r_phase == P_LD1);

  // w_enter marks any move into a new phase, including the line_start entry
  // into slot 0 phase 0; the leaving-SCAN move raises w_flush instead.
  always_comb begin
    w_state_nx    = r_state;
    w_slot_nx     = r_slot;
    w_phase_nx    = r_phase;
    w_enter       = 1'b0;
    w_flush       = 1'b0;
    w_overrun_set = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (line_start) begin
          w_state_nx = SCAN;
          w_slot_nx  = '0;
          w_phase_nx = P_SCAN;
          w_enter    = 1'b1;
        end
      end
      SCAN: begin
        if (line_start) begin
          w_slot_nx     = '0;
          w_phase_nx    = P_SCAN;
          w_enter       = 1'b1;
          w_overrun_set = ~w_last_tick;
        end else if (pix_ce) begin
          if (r_phase == P_LD1) begin
            w_phase_nx = P_SCAN;
            if (r_slot == LAST_SLOT) begin
              w_state_nx = IDLE;
              w_slot_nx  = '0;
              w_flush    = 1'b1;
            end else begin
              w_slot_nx = r_slot + SLOT_W'(1);
              w_enter   = 1'b1;
            end
          end else begin
            w_phase_nx = r_phase + PHASE_W'(1);
            w_enter    = 1'b1;
          end
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (VIDEO_RST) begin
      r_vckn    <= 1'b1;
      r_vlk     <= 1'b0;
      r_fck     <= 1'b0;
      r_ldn     <= 1'b1;
      r_lc      <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_vckn    <= ~(w_enter && (w_phase_nx == P_SCAN));
      r_vlk     <= w_enter && (w_phase_nx == P_VLK);
      r_fck     <= w_enter && (w_phase_nx == P_FCK);
      r_ldn     <= ~(w_enter && ((w_phase_nx == P_LD0) || (w_phase_nx == P_LD1)));
      r_lc      <= (w_enter && (w_phase_nx == P_SCAN) && (w_slot_nx != '0)) || w_flush;
      r_overrun <= r_overrun | w_overrun_set;
    end
  end

  // Qualified on the upcoming state, so a grant can never share a clk with VCKn=0.
  assign w_window_nx = (w_state_nx == IDLE) || is_free_phase(w_phase_nx);

  tnkiii_front_cpu_arb #(
    .ADDR_W(ADDR_W)
  ) u_cpu_arb (
    .clk         (clk),
    .i_rst       (VIDEO_RST),
    .i_window    (w_window_nx),
    .i_req       (cpu_req),
    .i_we        (cpu_we),
    .i_addr      (cpu_addr),
    .i_wdata     (cpu_wdata),
    .i_ram_rdata (ram_rdata),
    .o_ack       (cpu_ack),
    .o_rdata     (cpu_rdata),
    .o_va        (VA),
    .o_vd        (VD_out),
    .o_csn       (FRONT_CSn),
    .o_vwe       (VWE)
  );

  assign FH       = r_slot[SLOT_W-1:1];
  assign H3       = r_slot[0];
  assign VCKn     = r_vckn;
  assign VLK      = r_vlk;
  assign FCK      = r_fck;
  assign FCK_HALF = r_phase[PHASE_W-1];
  assign LD       = r_ldn;
  assign LC       = r_lc;
  assign busy     = (r_state == SCAN);
  assign overrun  = r_overrun;

endmodule
